// File: rtl/single_argmax_v_if.sv
// Handshake and result bundle for the single-precision argmax scanner.
interface single_argmax_v_if #(
   parameter int WIDTH = 10
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic                  start;
   logic [32*WIDTH-1:0]   vector_a;
   logic                  busy;
   logic                  done;
   logic [IDX_W-1:0]      index;
   logic [31:0]           max_value;
   logic                  nan_flag;

   modport master (
      output start, vector_a,
      input  busy, done, index, max_value, nan_flag
   );

   modport slave (
      input  start, vector_a,
      output busy, done, index, max_value, nan_flag
   );
endinterface

// File: rtl/single_argmax_v.sv
// Sequential argmax over a captured vector of IEEE-754 singles, one element
// per cycle, using a sign-magnitude compare (no float arithmetic).
//
// state  | meaning
// IDLE   | waiting for start, results held
// SCAN   | comparing buffered elements 1..WIDTH-1, busy high
// FINISH | done pulse, results just updated; start here chains a new scan
module single_argmax_v #(
   parameter int WIDTH = 10
) (
   input logic              clk,
   input logic              rst,
   single_argmax_v_if.slave bus
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

   state_t              state_q, state_d;
   logic [32*WIDTH-1:0] buf_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [31:0]         run_max_q, run_max_d;
   logic [IDX_W-1:0]    run_idx_q, run_idx_d;
   logic                run_nan_q, run_nan_d;
   logic [31:0]         max_q;
   logic [IDX_W-1:0]    idx_q;
   logic                nan_q;
   logic [31:0]         cand;
   logic [31:0]         elem0;
   logic                accept;
   logic                last;

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   // Strict a > b; both zeros compare equal regardless of sign.
   function automatic logic greater(input logic [31:0] a, input logic [31:0] b);
      if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
      if (a[31] != b[31]) return b[31];
      if (!a[31]) return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
   endfunction

   assign elem0  = bus.vector_a[31:0];
   assign cand   = buf_q[32*cnt_q +: 32];
   assign last   = (cnt_q == CNT_W'(WIDTH - 1));
   assign accept = bus.start && (state_q != SCAN);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start is ignored while scanning.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (WIDTH == 1) ? FINISH : SCAN;
         SCAN:    if (last)   state_d = FINISH;
         FINISH:  state_d = bus.start ? ((WIDTH == 1) ? FINISH : SCAN) : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // One compare step; a NaN running max (element 0 was NaN) yields to any number.
   always_comb begin
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      run_nan_d = run_nan_q;
      if (is_nan(cand)) begin
         run_nan_d = 1'b1;
      end else if (is_nan(run_max_q) || greater(cand, run_max_q)) begin
         run_max_d = cand;
         run_idx_d = cnt_q[IDX_W-1:0];
      end
   end

   // Capture, scan datapath, and result registers that only move at done.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q     <= '0;
         cnt_q     <= '0;
         run_max_q <= '0;
         run_idx_q <= '0;
         run_nan_q <= 1'b0;
         max_q     <= '0;
         idx_q     <= '0;
         nan_q     <= 1'b0;
      end else if (accept) begin
         buf_q     <= bus.vector_a;
         cnt_q     <= CNT_W'(1);
         run_max_q <= elem0;
         run_idx_q <= '0;
         run_nan_q <= is_nan(elem0);
         if (WIDTH == 1) begin
            max_q <= elem0;
            idx_q <= '0;
            nan_q <= is_nan(elem0);
         end
      end else if (state_q == SCAN) begin
         cnt_q     <= cnt_q + CNT_W'(1);
         run_max_q <= run_max_d;
         run_idx_q <= run_idx_d;
         run_nan_q <= run_nan_d;
         if (last) begin
            max_q <= run_max_d;
            idx_q <= run_idx_d;
            nan_q <= run_nan_d;
         end
      end
   end

   assign bus.busy      = (state_q == SCAN);
   assign bus.done      = (state_q == FINISH);
   assign bus.index     = idx_q;
   assign bus.max_value = max_q;
   assign bus.nan_flag  = nan_q;
endmodule

// File: doc/single_argmax_v.md
SINGLE_ARGMAX_V -- requirements
Module: single_argmax_v

Interface
REQ-001 SHALL have parameter WIDTH, default 10: number of single-precision elements in the input vector (legal range 1..1024).
REQ-002 SHALL have clk  input  1  clock; every register updates on the rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have start  input  1  one-cycle request to sample vector_a and begin a scan.
REQ-005 SHALL have vector_a  input  32 x WIDTH  IEEE-754 single-precision elements, typically sigmoid-layer outputs.
REQ-006 SHALL have busy  output  1  high while a scan is in progress.
REQ-007 SHALL have done  output  1  one-cycle pulse when index/max_value/nan_flag are valid.
REQ-008 SHALL have index  output  max(1,$clog2(WIDTH))  position of the largest element.
REQ-009 SHALL have max_value  output  32  bit pattern of the largest element.
REQ-010 SHALL have nan_flag  output  1  at least one sampled element was NaN.

Function
REQ-011 SHALL implement states IDLE, SCAN and FINISH.
REQ-012 SHALL accept start only in IDLE or FINISH; start in SCAN SHALL be ignored, with no effect on the current scan.
REQ-013 On an accepted start at edge T, SHALL capture all of vector_a into an internal buffer; later changes to vector_a SHALL NOT affect the result.
REQ-014 At edge T, SHALL seed the running maximum with element 0 (index 0) and the element counter with 1.
REQ-015 SHALL compare one buffered element per cycle in SCAN, elements 1..WIDTH-1 in ascending order.
REQ-016 SHALL assert done exactly WIDTH cycles after the accepted start edge (WIDTH=1: next cycle), in state FINISH, for exactly one cycle.
REQ-017 busy SHALL be 1 in SCAN and 0 in IDLE and FINISH.
REQ-018 Ordering SHALL be a sign-magnitude float compare with no float arithmetic.
- For two non-negative values, the larger magnitude wins.
- For two negative values, the smaller magnitude wins.
- Any positive value beats any negative value.
- +0 and -0 SHALL compare equal.
- +inf and -inf SHALL obey the same rules as finite values.
REQ-019 The running maximum SHALL be replaced only when the candidate is strictly greater; ties therefore keep the lowest index.
REQ-020 NaN (exponent 0xFF, mantissa nonzero) SHALL never win a comparison and SHALL set nan_flag for that scan.
REQ-021 If element 0 is NaN, the first later non-NaN element SHALL replace it unconditionally.
REQ-022 If all elements are NaN, SHALL report index=0 and max_value=element 0, with nan_flag=1.
REQ-023 index, max_value and nan_flag SHALL update only at the done edge and SHALL hold until the next done or reset.
REQ-024 nan_flag SHALL be cleared at the start of each accepted scan.
REQ-025 Start coincident with done (FINISH state) SHALL be accepted; the next done follows WIDTH cycles later, back-to-back.
REQ-026 FINISH SHALL go to IDLE when start=0 and to SCAN when start=1 (WIDTH>1) or stay in FINISH when start=1 (WIDTH=1).
REQ-027 The element counter SHALL be wide enough for WIDTH with no wrap-around.

Reset
REQ-028 With rst=1 at an edge, SHALL enter IDLE and drive busy=0, done=0, index=0, max_value=0 and nan_flag=0.
REQ-029 Reset SHALL take priority over start in the same cycle.
REQ-030 Reset during SCAN SHALL abort the scan with no done pulse and no output update.

Verification
REQ-031 WIDTH=4, vector_a={3F800000, 40000000, BF800000, 3F000000}, start at edge T -> done at T+4, index=1, max_value=40000000, nan_flag=0, busy high for cycles T+1..T+3.
REQ-032 WIDTH=4, {C0000000, BF800000, C0400000, 80000000} -> index=3, max_value=80000000; then {00000000, 80000000, 00000000, BF800000} -> index=0 (tie, lowest index).
REQ-033 WIDTH=4, {7FC00000, 3F800000, 7F800001, 3F800000} -> index=1, max_value=3F800000, nan_flag=1; all four elements 7FC00000 -> index=0, max_value=7FC00000, nan_flag=1.
REQ-034 WIDTH=10, start asserted in the done cycle, with vector_a changed the cycle after each start -> two done pulses 10 cycles apart, each matching its captured vector; start pulses during SCAN are ignored.
REQ-035 WIDTH=10, rst=1 at T+5 after a start at T -> no done pulse, all outputs 0; a new start at T+7 -> done at T+17.
REQ-036 WIDTH=1, {FF800000} -> done at T+1, index=0, max_value=FF800000.
